// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, 11-bit frame deserialiser
// with start/stop/odd-parity checking, and a scan-code FIFO with ready/nextdata_n pop.
module ps2_rx_fifo #(
  parameter int unsigned ADDR_W  = 3,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              nextdata_n,
  output logic [7:0]        data,
  output logic              ready,
  output logic              overflow,
  output logic              sampling,
  output logic              frame_err,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned   DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  logic              s0, s1, s2, d0, d1;
  logic              fall;
  logic [3:0]        bit_cnt;
  logic [10:0]       shreg;
  logic [10:0]       frm;
  logic [15:0]       tcnt;
  logic              stop_edge, good, push, pop, full, wr_en;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;

  // Synchronisers idle high, matching an undriven PS/2 bus
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s0 <= 1'b1; s1 <= 1'b1; s2 <= 1'b1;
      d0 <= 1'b1; d1 <= 1'b1;
    end else begin
      s0 <= ps2_clk;  s1 <= s0; s2 <= s1;
      d0 <= ps2_data; d1 <= d0;
    end
  end

  assign fall     = s2 & ~s1;
  assign sampling = fall;

  // The stop bit is checked as it arrives, so frm overlays d1 at position 10
  always_comb begin
    frm     = shreg;
    frm[10] = d1;
  end

  assign stop_edge = fall && (bit_cnt == 4'd10);
  assign good      = ~frm[0] & frm[10] & (^frm[9:1]);
  assign frame_err = stop_edge & ~good;
  assign push      = stop_edge & good;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bit_cnt <= '0;
      shreg   <= '0;
      tcnt    <= '0;
    end else if (fall) begin
      for (int unsigned i = 0; i < 11; i++) begin
        if (bit_cnt == i[3:0]) shreg[i] <= d1;
      end
      bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
      tcnt    <= '0;
    end else if (bit_cnt == 4'd0) begin
      tcnt <= '0;
    end else if (tcnt == TIMEOUT) begin
      tcnt    <= '0;
      bit_cnt <= '0;
    end else begin
      tcnt <= tcnt + 16'd1;
    end
  end

  assign ready = (count != '0);
  assign full  = (count == FULL_CNT);
  assign pop   = ready & ~nextdata_n;
  // A pop in the same cycle frees the slot a full FIFO needs for the push
  assign wr_en = push & (~full | pop);
  assign data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= frm[8:1];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed test-plan steps plus random
// frames, checked against a queue-based model of the scan-code FIFO.
module tb_ps2_rx_fifo;

  localparam int unsigned ADDR_W = 3;
  localparam logic [15:0] TO     = 16'd1000;

  logic             clk = 1'b0;
  logic             clr = 1'b1;
  logic             ps2_clk = 1'b1;
  logic             ps2_data = 1'b1;
  logic             nextdata_n = 1'b1;
  logic [7:0]       data;
  logic             ready, overflow, sampling, frame_err;
  logic [ADDR_W:0]  count;

  ps2_rx_fifo #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready), .overflow(overflow),
    .sampling(sampling), .frame_err(frame_err), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int samp_cnt = 0;
  int ferr_cnt = 0;

  logic [7:0] q[$];
  logic       ov = 1'b0;
  logic       rdy_at_stop, rdy_after;
  logic [7:0] data_at_stop;

  always @(negedge clk) begin
    if (sampling === 1'b1)  samp_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 good, 1 parity flipped, 2 start high, 3 stop low
  function automatic logic [10:0] make_frame(input logic [7:0] d, input int kind);
    logic [10:0] f;
    f = {1'b1, ~(^d), d, 1'b0};
    case (kind)
      1: f[9]  = ~f[9];
      2: f[0]  = 1'b1;
      3: f[10] = 1'b0;
      default: ;
    endcase
    return f;
  endfunction

  // Drives nbits of a frame at ~20 clk per PS/2 clock, waiting for each sampling pulse
  task automatic send_bits(input logic [10:0] f, input int nbits, input logic pop_at_stop);
    int  k;
    logic seen;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      seen = 1'b0;
      k = 0;
      while (!seen && k < 8) begin
        @(negedge clk);
        k++;
        if (sampling === 1'b1) seen = 1'b1;
      end
      if (!seen) check("edge_detect", {31'd0, seen}, 32'd1);
      if (i == 10) begin
        rdy_at_stop  = ready;
        data_at_stop = data;
        if (pop_at_stop) nextdata_n = 1'b0;
        @(negedge clk);
        k++;
        nextdata_n = 1'b1;
        rdy_after  = ready;
      end
      repeat (10 - k) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (5) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic verify_state(input string tag);
    check({tag, "_count"}, {28'd0, count}, q.size());
    check({tag, "_ready"}, {31'd0, ready}, {31'd0, q.size() != 0});
    check({tag, "_ovf"},   {31'd0, overflow}, {31'd0, ov});
    if (q.size() != 0) check({tag, "_data"}, {24'd0, data}, {24'd0, q[0]});
  endtask

  task automatic send_frame(input logic [7:0] d, input int kind, input logic pop_at_stop);
    int fe0;
    fe0 = ferr_cnt;
    send_bits(make_frame(d, kind), 11, pop_at_stop);
    if (pop_at_stop && q.size() != 0) begin
      check("data_at_pop", {24'd0, data_at_stop}, {24'd0, q[0]});
      void'(q.pop_front());
    end
    if (kind == 0) begin
      if (q.size() < 2 ** ADDR_W) q.push_back(d);
      else ov = 1'b1;
    end
    check("frame_err_pulses", ferr_cnt - fe0, (kind != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic pop_one();
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
    if (q.size() != 0) void'(q.pop_front());
    @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    q.delete();
    ov = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int s0, fe0, np, kind;
    logic [7:0] d;

    repeat (3) @(negedge clk);
    check("rst_ready",    {31'd0, ready},     32'd0);
    check("rst_overflow", {31'd0, overflow},  32'd0);
    check("rst_sampling", {31'd0, sampling},  32'd0);
    check("rst_frame_err",{31'd0, frame_err}, 32'd0);
    check("rst_count",    {28'd0, count},     32'd0);
    check("rst_data",     {24'd0, data},      32'd0);
    clr = 1'b0;
    repeat (3) @(negedge clk);

    // Single good frame: pulse count and push latency
    s0 = samp_cnt;
    send_frame(8'h1C, 0, 1'b0);
    check("t1_pulses", samp_cnt - s0, 32'd11);
    check("t1_ready_at_stop", {31'd0, rdy_at_stop}, 32'd0);
    check("t1_ready_next",    {31'd0, rdy_after},   32'd1);
    verify_state("t1");
    pop_one();
    verify_state("t1_pop");

    // Bad parity
    send_frame(8'h1C, 1, 1'b0);
    verify_state("t2");

    // Fill, overflow, drain, pop while empty
    for (int i = 1; i <= 8; i++) send_frame(i[7:0], 0, 1'b0);
    verify_state("t3_full");
    send_frame(8'h09, 0, 1'b0);
    verify_state("t3_ovf");
    for (int i = 0; i < 8; i++) begin
      verify_state("t3_drain");
      pop_one();
    end
    verify_state("t3_empty");
    pop_one();
    verify_state("t3_empty_pop");

    // Push and pop in the same cycle while full
    do_clr();
    for (int i = 1; i <= 8; i++) send_frame(i[7:0], 0, 1'b0);
    send_frame(8'h09, 0, 1'b1);
    verify_state("t4_full_pushpop");
    for (int i = 0; i < 8; i++) begin
      verify_state("t4_drain");
      pop_one();
    end
    verify_state("t4_empty");

    // Abandoned partial frame recovers through the timeout
    fe0 = ferr_cnt;
    send_bits(make_frame(8'hA7, 0), 5, 1'b0);
    repeat (int'(TO) + 5) @(negedge clk);
    send_frame(8'h5A, 0, 1'b0);
    verify_state("t5");
    check("t5_no_frame_err", ferr_cnt - fe0, 32'd0);
    pop_one();

    // Reset mid-frame
    send_bits(make_frame(8'h3C, 0), 6, 1'b0);
    do_clr();
    verify_state("t6_after_clr");
    send_frame(8'hF0, 0, 1'b0);
    verify_state("t6");

    // Random frames, errors and pops
    for (int it = 0; it < 24; it++) begin
      d    = 8'($urandom);
      kind = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      send_frame(d, kind, 1'($urandom_range(0, 1)));
      verify_state("rnd");
      np = int'($urandom_range(0, 2));
      for (int j = 0; j < np; j++) pop_one();
      verify_state("rnd_pop");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- PS/2 device-to-host receiver. Sits directly upstream of the keyboard scan-code FSM / ASCII / key-counter stage.
- Synchronises the raw ps2_clk/ps2_data pins, deserialises 11-bit frames and checks them.
- Good scan codes go into a FIFO. The consumer reads each code through a ready / nextdata_n handshake.

Parameters:
- ADDR_W, 3, FIFO address width; depth = 2**ADDR_W (8).
- TIMEOUT, 16'd50000, clk cycles with no ps2_clk falling edge before a partial frame is abandoned.

Ports:
- clk  in  1  system clock; all state on rising edge.
- clr  in  1  asynchronous active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- nextdata_n  in  1  active-low pop request, sampled each clk.
- data  out  8  scan code at the FIFO head; valid while ready=1.
- ready  out  1  FIFO non-empty.
- overflow  out  1  sticky: a good frame arrived while FIFO full.
- sampling  out  1  1-cycle pulse on each detected ps2_clk falling edge.
- frame_err  out  1  1-cycle pulse when a completed frame fails its checks.
- count  out  ADDR_W+1  FIFO occupancy, 0..2**ADDR_W.

Behaviour:
- Reset (async, clr=1): all FIFO pointers, count, bit counter, shift register and timeout counter go to 0. Synchroniser flops go to 1 (idle bus). Outputs: ready=0, overflow=0, sampling=0, frame_err=0, count=0, data=8'h00.
- Synchroniser: ps2_clk passes through a 3-flop shift (s0→s1→s2). ps2_data passes through a 2-flop shift (d0→d1).
- Falling-edge detect: fall = s2 & ~s1. sampling = fall, decoded directly from flops, one cycle wide.
- Edge latency: fall is seen 2–3 clk after the pin falls.
- Bit sampling: on fall, d1 is shifted into the frame register at position bit_cnt, then bit_cnt increments (0..10).
- Frame check at fall with bit_cnt==10 (stop bit); bit_cnt returns to 0 on the same edge. A frame is good only if all three hold:
  - bit0 (start) == 0
  - bit10 (stop) == 1
  - ^bits[9:1] == 1 (odd parity)
- Bad frame: frame_err=1 for that single cycle; nothing is written to the FIFO.
- Good frame: bits[8:1] are pushed (LSB first on the wire).
- Push timing: the FIFO entry is written on the same clk edge as the stop-bit fall. ready/count update the following cycle (1-cycle latency from the stop-bit sampling pulse).
- Pop rule: pop = ready & ~nextdata_n.
  - Each clk with pop=1 advances the read pointer by one.
  - A consumer holding nextdata_n low pops one entry per clk.
  - nextdata_n low while empty is ignored.
- data = mem[rd_ptr], combinational from pointer and memory.
- Simultaneous push and pop:
  - When full: the pop frees the slot, the push is accepted, count stays 2**ADDR_W, overflow is NOT set.
  - When empty: the pop is ignored, the push is accepted, count becomes 1.
- Full without pop: the good frame is discarded, overflow is set to 1 and stays 1 until clr. FIFO contents are unchanged.
- Pointers are ADDR_W bits and wrap modulo depth. count alone distinguishes full from empty.
- Timeout:
  - Counter clears on every fall and whenever bit_cnt==0.
  - Otherwise it increments while bit_cnt!=0.
  - On reaching TIMEOUT, bit_cnt and the counter clear. No frame_err, no push.
  - Recovers from a glitch or a mid-frame unplug.
- clr asserted mid-frame: the partial frame is lost. After release the receiver waits for a fresh start bit; FIFO is empty.

Test Plan:
- Send code 8'h1C (wire bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1), ps2_clk period 20 clk → exactly 11 sampling pulses; ready rises 1 clk after the 11th pulse; data=8'h1C, count=1; pulse nextdata_n low 1 clk → ready=0, count=0.
- Send 8'h1C with parity bit forced 1 → frame_err pulses once at the stop bit; ready stays 0, count=0.
- Send 8 codes 8'h01..8'h08 without popping → count=8, data=8'h01; a 9th code 8'h09 → overflow=1, count=8; pop 8 times → data sequence 01..08, then ready=0, overflow still 1.
- FIFO full, nextdata_n held low across the clk where a 9th good frame is written → no overflow, count stays 8, 8'h09 appears after 8'h02..8'h08 (wrap-around verified).
- Send 5 bits, then hold ps2_clk high for TIMEOUT+5 clk, then a full 8'h5A frame → count=1, data=8'h5A, frame_err never asserted.
- Assert clr after 6 bits of a frame, release, send 8'hF0 → count=1, data=8'hF0, overflow=0.
